tick_timer: RTL and testbench

TICK_TIMER -- requirements
Module: tick_timer

---
 rtl/tick_timer_pkg.sv | 14 +
 rtl/tick_timer.sv | 97 +++++++++
 tb/tb_tick_timer.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/tick_timer_pkg.sv
// tick_timer_pkg: shared encodings and defaults for the tick_timer block.
package tick_timer_pkg;

    localparam int DEFAULT_WIDTH = 23;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/tick_timer.sv
// tick_timer: programmable tick generator with periodic and one-shot modes.
// A period P yields one registered tick pulse every P+1 enabled cycles.
// Optional feature macro: TICK_TIMER_TICK_COUNT_EN adds an 8-bit saturating
// tick_count output, cleared by reset and by load.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_RUN  | counting toward period_q, busy=1, ticks on terminal count
// ST_DONE | one-shot has expired; count parked at 0, waits for load
module tick_timer
    import tick_timer_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             mode,
    input  logic             load,
    input  logic [WIDTH-1:0] period,
    output logic             tick,
    output logic             busy,
`ifdef TICK_TIMER_TICK_COUNT_EN
    output logic [7:0]       tick_count,
`endif
    output logic [WIDTH-1:0] count
);

    state_t           state_q;
    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] period_q;
    logic             tick_q;
    logic             expire;

    // Increment wraps modulo 2^WIDTH; reset leaves period_q all ones so the
    // free-running default wraps exactly at the counter width.
    assign count_d = count_q + WIDTH'(1);
    assign expire  = (state_q == ST_RUN) && enable && (count_q == period_q);

    // Timer FSM, counter and period register; load outranks terminal count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_RUN;
            count_q  <= '0;
            period_q <= '1;
            tick_q   <= 1'b0;
        end else if (load) begin
            state_q  <= ST_RUN;
            count_q  <= '0;
            period_q <= period;
            tick_q   <= 1'b0;
        end else begin
            tick_q <= expire;
            case (state_q)
                ST_RUN: begin
                    if (expire) begin
                        count_q <= '0;
                        if (mode == MODE_ONESHOT) begin
                            state_q <= ST_DONE;
                        end
                    end else if (enable) begin
                        count_q <= count_d;
                    end
                end
                ST_DONE: begin
                    count_q <= '0;
                end
                default: begin
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

`ifdef TICK_TIMER_TICK_COUNT_EN
    logic [7:0] tick_cnt_q;

    // Count expiries, sticking at 255 rather than wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tick_cnt_q <= 8'd0;
        end else if (load) begin
            tick_cnt_q <= 8'd0;
        end else if (expire && (tick_cnt_q != 8'hFF)) begin
            tick_cnt_q <= tick_cnt_q + 8'd1;
        end
    end

    assign tick_count = tick_cnt_q;
`endif

    assign tick  = tick_q;
    assign busy  = (state_q == ST_RUN);
    assign count = count_q;

endmodule

// File: tb/tb_tick_timer.sv
// tb_tick_timer: directed scenarios plus randomized traffic for tick_timer,
// compared cycle by cycle against an elapsed-cycle reference model.
module tb_tick_timer;

    localparam int W    = 4;
    localparam int MAXP = (1 << W) - 1;

    logic         clk    = 1'b0;
    logic         reset  = 1'b1;
    logic         enable = 1'b0;
    logic         mode   = 1'b0;
    logic         load   = 1'b0;
    logic [W-1:0] period = '0;
    logic         tick;
    logic         busy;
    logic [W-1:0] count;
`ifdef TICK_TIMER_TICK_COUNT_EN
    logic [7:0]   tick_count;
`endif

    tick_timer #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .mode       (mode),
        .load       (load),
        .period     (period),
        .tick       (tick),
        .busy       (busy),
`ifdef TICK_TIMER_TICK_COUNT_EN
        .tick_count (tick_count),
`endif
        .count      (count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: elapsed enabled cycles since the last load/reset.
    // The count is that total modulo P+1; an expiry is any enabled cycle that
    // lands the total on a multiple of P+1.
    int     m_p;
    longint m_n;
    bit     m_run;
    bit     m_tick;
    int     m_tc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_p    = MAXP;
        m_n    = 0;
        m_run  = 1'b1;
        m_tick = 1'b0;
        m_tc   = 0;
    endfunction

    function automatic void model_edge(input bit en, input bit md, input bit ld, input int per);
        if (ld) begin
            m_p    = per;
            m_n    = 0;
            m_run  = 1'b1;
            m_tick = 1'b0;
            m_tc   = 0;
        end else if (m_run && en) begin
            m_n++;
            m_tick = ((m_n % (m_p + 1)) == 0);
            if (m_tick) begin
                if (m_tc < 255) m_tc++;
                if (md) m_run = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
        end
    endfunction

    task automatic compare_all(input string ctx);
        check({ctx, ".tick"}, 32'(tick), 32'(m_tick));
        check({ctx, ".busy"}, 32'(busy), 32'(m_run));
        check({ctx, ".count"}, 32'(count), m_run ? 32'(m_n % (m_p + 1)) : 32'd0);
`ifdef TICK_TIMER_TICK_COUNT_EN
        check({ctx, ".tick_count"}, 32'(tick_count), 32'(m_tc));
`endif
    endtask

    task automatic step(input string ctx, input bit en, input bit md, input bit ld, input int per);
        enable = en;
        mode   = md;
        load   = ld;
        period = W'(per);
        @(posedge clk);
        model_edge(en, md, ld, per);
        #1;
        compare_all(ctx);
        load = 1'b0;
    endtask

    // Assert reset between edges and check the outputs clear with no clock.
    task automatic async_reset();
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        compare_all("async_rst");
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] mask;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all("por");
        @(negedge clk);
        reset = 1'b0;

        // periodic P=3: ticks at cycles 4, 8, 12
        step("p3_load", 1, 0, 1, 3);
        mask = 0;
        for (int i = 1; i <= 12; i++) begin
            step("p3", 1, 0, 0, 0);
            if (tick) mask |= (32'd1 << i);
        end
        check("p3_tick_cycles", mask, (32'd1 << 4) | (32'd1 << 8) | (32'd1 << 12));

        // one-shot P=2: single tick at cycle 3, then silence
        step("os_load", 1, 1, 1, 2);
        mask = 0;
        for (int i = 1; i <= 23; i++) begin
            step("os", 1, 1, 0, 0);
            if (tick) mask |= (32'd1 << i);
        end
        check("os_tick_cycles", mask, 32'd1 << 3);

        // P=5 paused for 3 cycles at count=2: tick slips from 6 to 9
        step("pause_load", 1, 0, 1, 5);
        mask = 0;
        for (int i = 1; i <= 12; i++) begin
            step("pause", (i < 3 || i > 5), 0, 0, 0);
            if (tick) mask |= (32'd1 << i);
        end
        check("pause_tick_cycles", mask, 32'd1 << 9);

        // load P=7 exactly at terminal count: no tick, next tick 8 later
        step("tc_load_a", 1, 0, 1, 3);
        for (int i = 1; i <= 3; i++) step("tc_run", 1, 0, 0, 0);
        step("tc_load_b", 1, 0, 1, 7);
        mask = 0;
        for (int i = 1; i <= 10; i++) begin
            step("tc_after", 1, 0, 0, 0);
            if (tick) mask |= (32'd1 << i);
        end
        check("tc_tick_cycles", mask, 32'd1 << 8);

        // reset mid-count, free-running default, then P=0
        step("rst_load", 1, 0, 1, 3);
        step("rst_run", 1, 0, 0, 0);
        step("rst_run", 1, 0, 0, 0);
        async_reset();
        mask = 0;
        for (int i = 1; i <= 20; i++) begin
            step("free", 1, 0, 0, 0);
            if (tick) mask |= (32'd1 << i);
        end
        check("free_tick_cycles", mask, 32'd1 << 16);
        step("p0_load", 1, 0, 1, 0);
        mask = 0;
        for (int i = 1; i <= 5; i++) begin
            step("p0", 1, 0, 0, 0);
            if (tick) mask |= (32'd1 << i);
        end
        check("p0_tick_cycles", mask, 32'd62);

`ifdef TICK_TIMER_TICK_COUNT_EN
        step("sat_load", 1, 0, 1, 0);
        for (int i = 1; i <= 300; i++) step("sat", 1, 0, 0, 0);
        check("sat_tick_count", 32'(tick_count), 32'd255);
        step("sat_reload", 1, 0, 1, 4);
        check("sat_cleared", 32'(tick_count), 32'd0);
`endif

        // randomized traffic
        begin
            bit md = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                if ($urandom_range(0, 15) == 0) md = ~md;
                if ($urandom_range(0, 499) == 0) begin
                    async_reset();
                end else begin
                    step("rand",
                         ($urandom_range(0, 7) != 0),
                         md,
                         ($urandom_range(0, 23) == 0),
                         int'($urandom_range(0, MAXP)));
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
